sd_cmd_sequencer: RTL and testbench

SD_CMD_SEQUENCER -- requirements
Module: sd_cmd_sequencer

---
 rtl/sd_regs_pkg.sv | 24 ++
 rtl/sd_bus_byte_port.sv | 59 +++++
 rtl/sd_cmd_sequencer.sv | 145 ++++++++++++++
 tb/tb_sd_cmd_sequencer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/sd_regs_pkg.sv
// Shared SD host register map and sequencer state encoding.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package sd_regs_pkg;

  // Byte offsets in the SD host register space
  localparam logic [6:0] REG_ARG0    = 7'h00;
  localparam logic [6:0] REG_CMD0    = 7'h04;
  localparam logic [6:0] REG_RESP0   = 7'h08;
  localparam logic [6:0] REG_CMD_ISR = 7'h34;

  typedef enum logic [3:0] {
    IDLE,
    CLR,
    SETTLE,
    WR_CMD,
    WR_ARG,
    POLL,
    RD_RESP,
    ACK,
    DONE
  } sd_state_t;

endpackage

// File: rtl/sd_bus_byte_port.sv
// Maps sequencer state plus byte index onto register bus address, data and write strobe.
// Latency: combinational from the registered state, so the bus is glitch-free per cycle.
// Backpressure: none; unused cycles park address and data at zero.
module sd_bus_byte_port
  import sd_regs_pkg::*;
#(
  parameter int CMD_W = 14
) (
  input  sd_state_t        state,
  input  logic [1:0]       idx,
  input  logic [CMD_W-1:0] cmd,
  input  logic [31:0]      arg,
  output logic             bus_we,
  output logic [6:0]       bus_addr,
  output logic [7:0]       bus_wdata
);

  logic [15:0] cmd_ext;

  assign cmd_ext = 16'(cmd);

  // Decode the byte access for the current step; argument goes high byte first so byte 0 launches
  always_comb begin
    bus_we    = 1'b0;
    bus_addr  = 7'h00;
    bus_wdata = 8'h00;
    case (state)
      CLR, ACK: begin
        bus_we    = 1'b1;
        bus_addr  = REG_CMD_ISR;
      end
      WR_CMD: begin
        bus_we    = 1'b1;
        bus_addr  = REG_CMD0 + {6'b0, idx[0]};
        bus_wdata = idx[0] ? cmd_ext[15:8] : cmd_ext[7:0];
      end
      WR_ARG: begin
        bus_we    = 1'b1;
        bus_addr  = REG_ARG0 + {5'b0, ~idx};
        case (idx)
          2'd0:    bus_wdata = arg[31:24];
          2'd1:    bus_wdata = arg[23:16];
          2'd2:    bus_wdata = arg[15:8];
          default: bus_wdata = arg[7:0];
        endcase
      end
      POLL: begin
        bus_addr  = REG_CMD_ISR;
      end
      RD_RESP: begin
        bus_addr  = REG_RESP0 + {5'b0, idx};
      end
      default: begin
        bus_we    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/sd_cmd_sequencer.sv
// Issues one SD host command over the byte register bus, polls for completion, reads response word 0.
// Latency: 1+SETTLE_CYC+2+4+polls+4+1+1 cycles from accepted start to done (22 with first poll set).
// Backpressure: none; start is ignored while busy and the register bus has fixed single-cycle timing.
module sd_cmd_sequencer
  import sd_regs_pkg::*;
#(
  parameter int CMD_W      = 14,
  parameter int SETTLE_CYC = 8,
  parameter int POLL_MAX   = 65535
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CMD_W-1:0] cmd_in,
  input  logic [31:0]      arg_in,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [31:0]      resp_out,
  output logic [4:0]       isr_out,
  output logic             bus_we,
  output logic [6:0]       bus_addr,
  output logic [7:0]       bus_wdata,
  input  logic [7:0]       bus_rdata
);

  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int PW = (POLL_MAX > 1) ? $clog2(POLL_MAX) : 1;

  sd_state_t        state;
  logic [1:0]       idx;
  logic [SW-1:0]    settle_cnt;
  logic [PW-1:0]    poll_cnt;
  logic [CMD_W-1:0] cmd_q;
  logic [31:0]      arg_q;

  // Command sequencing FSM with registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= 2'd0;
      settle_cnt <= '0;
      poll_cnt   <= '0;
      cmd_q      <= '0;
      arg_q      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      resp_out   <= '0;
      isr_out    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cmd_q    <= cmd_in;
            arg_q    <= arg_in;
            poll_cnt <= '0;
            timeout  <= 1'b0;
            resp_out <= '0;
            isr_out  <= '0;
            busy     <= 1'b1;
            state    <= CLR;
          end
        end
        CLR: begin
          settle_cnt <= '0;
          state      <= SETTLE;
        end
        SETTLE: begin
          if (settle_cnt == SW'(SETTLE_CYC - 1)) begin
            idx   <= 2'd0;
            state <= WR_CMD;
          end else begin
            settle_cnt <= settle_cnt + SW'(1);
          end
        end
        WR_CMD: begin
          if (idx == 2'd1) begin
            idx   <= 2'd0;
            state <= WR_ARG;
          end else begin
            idx <= idx + 2'd1;
          end
        end
        WR_ARG: begin
          if (idx == 2'd3) begin
            idx   <= 2'd0;
            state <= POLL;
          end else begin
            idx <= idx + 2'd1;
          end
        end
        POLL: begin
          if (bus_rdata[4:0] != 5'd0) begin
            isr_out <= bus_rdata[4:0];
            idx     <= 2'd0;
            state   <= RD_RESP;
          end else begin
            poll_cnt <= poll_cnt + PW'(1);
            if (poll_cnt == PW'(POLL_MAX - 1)) begin
              timeout  <= 1'b1;
              isr_out  <= '0;
              resp_out <= '0;
              state    <= ACK;
            end
          end
        end
        RD_RESP: begin
          resp_out[{idx, 3'b000} +: 8] <= bus_rdata;
          if (idx == 2'd3) begin
            idx   <= 2'd0;
            state <= ACK;
          end else begin
            idx <= idx + 2'd1;
          end
        end
        ACK: begin
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  sd_bus_byte_port #(
    .CMD_W (CMD_W)
  ) u_port (
    .state     (state),
    .idx       (idx),
    .cmd       (cmd_q),
    .arg       (arg_q),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata)
  );

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// Self-checking bench for sd_cmd_sequencer against a register-bus slave model.
// Latency: expected start-to-done cycle counts are derived from the step arithmetic.
// Backpressure: n/a.
module tb_sd_cmd_sequencer;

  localparam int CMD_W      = 14;
  localparam int SETTLE_CYC = 8;
  localparam int POLL_MAX   = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [CMD_W-1:0] cmd_in;
  logic [31:0]      arg_in;
  logic             busy;
  logic             done;
  logic             timeout;
  logic [31:0]      resp_out;
  logic [4:0]       isr_out;
  logic             bus_we;
  logic [6:0]       bus_addr;
  logic [7:0]       bus_wdata;
  logic [7:0]       bus_rdata;

  int tests = 0;
  int fails = 0;

  // Slave model state: number of zero polls before isr appears, isr value, response word
  int          m_zero = 0;
  logic [4:0]  m_isr  = 5'd0;
  logic [31:0] m_resp = 32'd0;
  logic        model_clr = 1'b0;
  int          polls_done = 0;

  // Monitor results
  logic [14:0] wq[$];
  int          rd08 = 0;
  int          done_cnt = 0;

  always #5 clk = ~clk;

  sd_cmd_sequencer #(
    .CMD_W      (CMD_W),
    .SETTLE_CYC (SETTLE_CYC),
    .POLL_MAX   (POLL_MAX)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cmd_in    (cmd_in),
    .arg_in    (arg_in),
    .busy      (busy),
    .done      (done),
    .timeout   (timeout),
    .resp_out  (resp_out),
    .isr_out   (isr_out),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata)
  );

  // Combinational register read port
  always_comb begin
    bus_rdata = 8'h00;
    case (bus_addr)
      7'h34: bus_rdata = (polls_done < m_zero) ? 8'h00 : {3'b000, m_isr};
      7'h08: bus_rdata = m_resp[7:0];
      7'h09: bus_rdata = m_resp[15:8];
      7'h0A: bus_rdata = m_resp[23:16];
      7'h0B: bus_rdata = m_resp[31:24];
      default: bus_rdata = 8'h00;
    endcase
  end

  // Count completed isr polls (a read of 0x34 with no write strobe)
  always @(posedge clk) begin
    if (model_clr) polls_done <= 0;
    else if (!bus_we && bus_addr == 7'h34) polls_done <= polls_done + 1;
  end

  // Log writes, response reads and done pulses mid-cycle
  always @(negedge clk) begin
    if (model_clr) begin
      wq.delete();
      rd08     = 0;
      done_cnt = 0;
    end else begin
      if (bus_we) wq.push_back({bus_addr, bus_wdata});
      if (!bus_we && bus_addr == 7'h08) rd08++;
      if (done) done_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    @(posedge clk); #1 model_clr = 1'b1;
    @(posedge clk);
    @(negedge clk); #1 model_clr = 1'b0;
  endtask

  // Expected write sequence: isr clear, cmd lo/hi, arg bytes high to low, isr ack
  task automatic expect_writes(input logic [CMD_W-1:0] c, input logic [31:0] a, input int n);
    logic [15:0] ce;
    logic [14:0] exp[8];
    ce = 16'(c);
    exp[0] = {7'h34, 8'h00};
    exp[1] = {7'h04, ce[7:0]};
    exp[2] = {7'h05, ce[15:8]};
    exp[3] = {7'h03, a[31:24]};
    exp[4] = {7'h02, a[23:16]};
    exp[5] = {7'h01, a[15:8]};
    exp[6] = {7'h00, a[7:0]};
    exp[7] = {7'h34, 8'h00};
    chk("write_count", wq.size(), n);
    for (int i = 0; i < n && i < wq.size(); i++) chk($sformatf("write%0d", i), 32'(wq[i]), 32'(exp[i]));
  endtask

  task automatic run_txn(input logic [CMD_W-1:0] c, input logic [31:0] a, input int zn,
                         input logic [4:0] it, input logic [31:0] rv, input bit poke);
    int  lat;
    int  cyc;
    bit  to;
    int  exp_lat;
    to = (zn >= POLL_MAX) || (it == 5'd0);
    exp_lat = to ? (1 + SETTLE_CYC + 2 + 4 + POLL_MAX + 1 + 1)
                 : (1 + SETTLE_CYC + 2 + 4 + (zn + 1) + 4 + 1 + 1);
    m_zero = zn;
    m_isr  = it;
    m_resp = rv;
    clear_model();
    cmd_in = c;
    arg_in = a;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cmd_in = ~c;
    arg_in = ~a;
    cyc = 1;
    lat = 0;
    chk("busy_after_start", busy, 1);
    while (lat == 0 && cyc < 300) begin
      if (done) lat = cyc;
      else begin
        start = poke && (cyc == 13 || cyc == 18);
        @(posedge clk); #1;
        cyc++;
      end
    end
    start = 1'b0;
    chk("done_latency", lat, exp_lat);
    chk("timeout", timeout, to);
    chk("resp_out", resp_out, to ? 32'd0 : rv);
    chk("isr_out", isr_out, to ? 5'd0 : it);
    @(posedge clk); #1;
    chk("busy_after_done", busy, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("done_pulses", done_cnt, 1);
    chk("resp_hold", resp_out, to ? 32'd0 : rv);
    chk("rd08_reads", rd08, to ? 0 : 1);
    expect_writes(c, a, 8);
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    cmd_in = '0;
    arg_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_resp", resp_out, 0);
    chk("rst_isr", isr_out, 0);
    chk("rst_we", bus_we, 0);
    chk("rst_addr", bus_addr, 0);
    chk("rst_wdata", bus_wdata, 0);
    rst = 1'b0;

    run_txn(14'h0011, 32'hDEADBEEF, 0, 5'h01, 32'h12345678, 1'b0);
    run_txn(14'h2A5C, 32'h0BADF00D, 10, 5'h05, 32'hCAFEF00D, 1'b0);
    run_txn(14'h1FFF, 32'h13579BDF, 1000, 5'h00, 32'hFFFFFFFF, 1'b0);
    run_txn(14'h0C35, 32'hA5A55A5A, 5, 5'h1F, 32'h87654321, 1'b1);

    // Reset in the middle of the command write
    m_zero = 0; m_isr = 5'h01; m_resp = 32'h0;
    clear_model();
    cmd_in = 14'h0033;
    arg_in = 32'h11223344;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("in_wr_cmd_we", bus_we, 1);
    chk("in_wr_cmd_addr", bus_addr, 7'h04);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_we", bus_we, 0);
    chk("abort_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    expect_writes(14'h0033, 32'h11223344, 2);
    chk("abort_no_done", done_cnt, 0);

    for (int t = 0; t < 6; t++) begin
      run_txn(CMD_W'($urandom), $urandom, $urandom_range(0, 20),
              5'($urandom_range(1, 31)), $urandom, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
